// File: rtl/deserializer_fsm.sv
// LSB-first bit-serial to LENGTH-bit parallel receiver with valid/ready on both sides.
// Latency: word valid right after the edge accepting its last bit; DESERIALIZER_SKID_EN overlaps the next word with the held one.
// Backpressure: held word stays until i_ready; o_ready drops while held (or only at the last bit with skid).
module deserializer_fsm #(
    parameter int LENGTH = 24
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic [LENGTH-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_ready
);

    localparam int CW = $clog2(LENGTH);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RX   = 3'b010,
        FULL = 3'b100
    } state_t;

    state_t            state, state_nxt;
    logic [LENGTH-1:0] shift_q, shift_nxt, dout_nxt;
    logic [CW-1:0]     cnt_q, cnt_nxt;
    logic              dout_valid_nxt;
    logic              accept, consume, last_bit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            ov_dout      <= '0;
            o_dout_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            shift_q      <= shift_nxt;
            cnt_q        <= cnt_nxt;
            ov_dout      <= dout_nxt;
            o_dout_valid <= dout_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        o_ready        = 1'b0;
        shift_nxt      = shift_q;
        cnt_nxt        = cnt_q;
        dout_nxt       = ov_dout;
        dout_valid_nxt = o_dout_valid;
        last_bit       = (cnt_q == CW'(LENGTH - 1));
        consume        = i_en & o_dout_valid & i_ready;

        case (state)
            IDLE: begin
                if (i_en)
                    state_nxt = RX;
            end
            RX: begin
`ifdef DESERIALIZER_SKID_EN
                // Final bit may only land if the held word leaves on the same edge.
                o_ready = !(last_bit && o_dout_valid && !i_ready);
`else
                o_ready = 1'b1;
`endif
            end
            FULL: begin
                if (consume)
                    state_nxt = RX;
            end
            default: state_nxt = IDLE;
        endcase

        accept = i_en & o_ready & i_din_valid;

        if (consume)
            dout_valid_nxt = 1'b0;

        if (accept) begin
            shift_nxt = {i_din, shift_q[LENGTH-1:1]};
            if (last_bit) begin
                dout_nxt       = {i_din, shift_q[LENGTH-1:1]};
                dout_valid_nxt = 1'b1;
                cnt_nxt        = '0;
`ifndef DESERIALIZER_SKID_EN
                state_nxt      = FULL;
`endif
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_deserializer_fsm.sv
// Directed bench for deserializer_fsm; expectations follow the build's DESERIALIZER_SKID_EN setting.
module tb_deserializer_fsm;

`ifdef DESERIALIZER_SKID_EN
    localparam int SPACING = 24;
`else
    localparam int SPACING = 25;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        rdy_out;
    logic [23:0] dout;
    logic        dout_valid;
    logic        ready_in = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [23:0] q_dat[$];
    int          q_cyc[$];

    deserializer_fsm #(.LENGTH(24)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_din        (din),
        .i_din_valid  (din_valid),
        .o_ready      (rdy_out),
        .ov_dout      (dout),
        .o_dout_valid (dout_valid),
        .i_ready      (ready_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every word handed downstream, sampled half a cycle before its consuming edge.
    always @(negedge clk) begin
        if (rst_n && en && dout_valid && ready_in) begin
            q_dat.push_back(dout);
            q_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 0; i < 24; i++) begin
            int   n;
            logic acc;
            n   = 0;
            acc = 1'b0;
            din       = w[i];
            din_valid = 1'b1;
            while (!acc && n < 100) begin
                @(negedge clk);
                acc = rdy_out && en;
                tick();
                n++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL send_word bit %0d of %h never accepted within 100 cycles", i, w);
                din_valid = 1'b0;
                return;
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (rdy_out !== 1'b0 || dout_valid !== 1'b0 || dout !== 24'h0) begin
            errors++;
            $display("FAIL reset_state ready=%b valid=%b dout=%h want 0/0/000000", rdy_out, dout_valid, dout);
        end
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (rdy_out !== 1'b1 || dout_valid !== 1'b0 || dout !== 24'h0) begin
                errors++;
                $display("FAIL idle_cycle%0d ready=%b valid=%b dout=%h want 1/0/000000", i, rdy_out, dout_valid, dout);
            end
        end
    endtask

    task automatic test_single();
        q_dat.delete();
        q_cyc.delete();
        ready_in = 1'b1;
        send_word(24'hA5C3F0);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 24'hA5C3F0) begin
            errors++;
            $display("FAIL single_word valid=%b dout=%h want 1/a5c3f0", dout_valid, dout);
        end
        tick();
        checks++;
        if (dout_valid !== 1'b0 || rdy_out !== 1'b1) begin
            errors++;
            $display("FAIL single_pulse valid=%b ready=%b want 0/1", dout_valid, rdy_out);
        end
        checks++;
        if (q_dat.size() != 1 || q_dat[0] !== 24'hA5C3F0) begin
            errors++;
            $display("FAIL single_consumed count=%0d want 1 of a5c3f0", q_dat.size());
        end
    endtask

    task automatic test_gapped();
        logic [23:0] w;
        w = 24'h000001;
        ready_in = 1'b1;
        for (int i = 0; i < 24; i++) begin
            // Invalid cycle carrying a 1 that must be ignored.
            din       = 1'b1;
            din_valid = 1'b0;
            tick();
            if (i == 10) begin
                en        = 1'b0;
                din_valid = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    checks++;
                    if (rdy_out !== 1'b1 || dout_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL gapped_disabled%0d ready=%b valid=%b want 1/0", k, rdy_out, dout_valid);
                    end
                end
                en = 1'b1;
            end
            if (i == 23) begin
                checks++;
                if (dout_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gapped_early valid=%b want 0 before final bit", dout_valid);
                end
            end
            din       = w[i];
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout !== 24'h000001) begin
            errors++;
            $display("FAIL gapped_word valid=%b dout=%h want 1/000001", dout_valid, dout);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [23:0] w2;
        w2 = 24'hFEDCBA;
        q_dat.delete();
        q_cyc.delete();
        ready_in = 1'b0;
        send_word(24'h123456);
`ifdef DESERIALIZER_SKID_EN
        for (int i = 0; i < 23; i++) begin
            din       = w2[i];
            din_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (rdy_out !== 1'b1 || dout !== 24'h123456 || dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_skid_bit%0d ready=%b dout=%h valid=%b want 1/123456/1", i, rdy_out, dout, dout_valid);
            end
            tick();
        end
        din       = w2[23];
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rdy_out !== 1'b0 || dout !== 24'h123456 || dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_skid_stall%0d ready=%b dout=%h valid=%b want 0/123456/1", i, rdy_out, dout, dout_valid);
            end
            tick();
        end
        ready_in = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_skid_release ready=%b want 1", rdy_out);
        end
        tick();
        din_valid = 1'b0;
        checks++;
        if (dout_valid !== 1'b1 || dout !== 24'hFEDCBA) begin
            errors++;
            $display("FAIL bp_skid_second valid=%b dout=%h want 1/fedcba", dout_valid, dout);
        end
        tick();
        checks++;
        if (q_dat.size() != 2 || q_dat[0] !== 24'h123456 || q_dat[1] !== 24'hFEDCBA) begin
            errors++;
            $display("FAIL bp_order count=%0d want 2 words 123456,fedcba", q_dat.size());
        end
`else
        din       = 1'b1;
        din_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (rdy_out !== 1'b0 || dout !== 24'h123456 || dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d ready=%b dout=%h valid=%b want 0/123456/1", i, rdy_out, dout, dout_valid);
            end
            tick();
        end
        ready_in = 1'b1;
        tick();
        din_valid = 1'b0;
        checks++;
        if (dout_valid !== 1'b0 || rdy_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_release valid=%b ready=%b want 0/1", dout_valid, rdy_out);
        end
        checks++;
        if (q_dat.size() != 1 || q_dat[0] !== 24'h123456) begin
            errors++;
            $display("FAIL bp_order count=%0d want 1 word 123456", q_dat.size());
        end
`endif
    endtask

    task automatic test_async_reset();
        logic [23:0] prev;
`ifdef DESERIALIZER_SKID_EN
        prev = 24'hFEDCBA;
`else
        prev = 24'h123456;
`endif
        checks++;
        if (dout !== prev) begin
            errors++;
            $display("FAIL arst_pre dout=%h want %h", dout, prev);
        end
        for (int i = 0; i < 10; i++) begin
            din       = 1'b1;
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy_out !== 1'b0 || dout_valid !== 1'b0 || dout !== 24'h0) begin
            errors++;
            $display("FAIL arst_clear ready=%b valid=%b dout=%h want 0/0/000000", rdy_out, dout_valid, dout);
        end
        #2;
        rst_n = 1'b1;
        tick();
        ready_in = 1'b1;
        send_word(24'h0F0F0F);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 24'h0F0F0F) begin
            errors++;
            $display("FAIL arst_next valid=%b dout=%h want 1/0f0f0f", dout_valid, dout);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [23:0] words[4];
        words[0] = 24'h111111;
        words[1] = 24'hABCDEF;
        words[2] = 24'h800001;
        words[3] = 24'h5A5A5A;
        q_dat.delete();
        q_cyc.delete();
        ready_in = 1'b1;
        for (int k = 0; k < 4; k++)
            send_word(words[k]);
        tick();
        tick();
        checks++;
        if (q_dat.size() != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d words want 4", q_dat.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (q_dat[k] !== words[k]) begin
                    errors++;
                    $display("FAIL b2b_data%0d got %h want %h", k, q_dat[k], words[k]);
                end
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (q_cyc[k] - q_cyc[k-1] != SPACING) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d got %0d want %0d", k, q_cyc[k] - q_cyc[k-1], SPACING);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gapped();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
